// File: rtl/rca_pipe_if.sv
// Operand/result handshake bundle for rca_pipe; the adder consumes it through the slave modport.
interface rca_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, ovf
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: STAGES slices of WIDTH/STAGES bits, one slice
// rippled per stage, valid/ready handshake with full back-pressure on both sides.
module rca_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic      clk,
  input  logic      rst,
  rca_pipe_if.slave bus
);
  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES:0] rdy;

  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0] & ~rst;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      // Operand registers shrink by one slice per stage and sum registers grow by one,
      // so no stage carries bits it will never read.
      localparam int unsigned IW = WIDTH - k * SW;
      localparam int unsigned OW = (k + 1) * SW;

      logic          vi;
      logic          ci;
      logic [IW-1:0] ai;
      logic [IW-1:0] bi;
      logic [SW:0]   sum;
      logic [OW-1:0] s_nx;
      logic          load;
      logic          vq;
      logic          cq;
      logic [OW-1:0] sq;

      if (k == 0) begin : g_head
        assign vi   = bus.in_valid;
        assign ai   = bus.a;
        assign bi   = bus.b ^ {WIDTH{bus.sub}};
        assign ci   = bus.cin ^ bus.sub;
        assign s_nx = sum[SW-1:0];
      end else begin : g_body
        assign vi   = g_stg[k-1].vq;
        assign ai   = g_stg[k-1].g_fwd.aq;
        assign bi   = g_stg[k-1].g_fwd.bq;
        assign ci   = g_stg[k-1].cq;
        assign s_nx = {sum[SW-1:0], g_stg[k-1].sq};
      end

      assign sum    = {1'b0, ai[SW-1:0]} + {1'b0, bi[SW-1:0]} + {{SW{1'b0}}, ci};
      assign rdy[k] = ~vq | rdy[k+1];
      assign load   = rdy[k] & vi;

      always_ff @(posedge clk) begin
        if (rst) begin
          vq <= 1'b0;
          cq <= 1'b0;
          sq <= '0;
        end else if (rdy[k]) begin
          vq <= vi;
          if (vi) begin
            cq <= sum[SW];
            sq <= s_nx;
          end
        end
      end

      if (k < LAST) begin : g_fwd
        logic [IW-SW-1:0] aq;
        logic [IW-SW-1:0] bq;

        always_ff @(posedge clk) begin
          if (rst) begin
            aq <= '0;
            bq <= '0;
          end else if (load) begin
            aq <= ai[IW-1:SW];
            bq <= bi[IW-1:SW];
          end
        end
      end else begin : g_out
        logic oq;

        // Carry into the MSB recovered from the MSB sum bit, xor carry out of the MSB.
        always_ff @(posedge clk) begin
          if (rst) begin
            oq <= 1'b0;
          end else if (load) begin
            oq <= ai[IW-1] ^ bi[IW-1] ^ sum[SW-1] ^ sum[SW];
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = g_stg[LAST].vq;
  assign bus.s         = {g_stg[LAST].cq, g_stg[LAST].sq};
  assign bus.ovf       = g_stg[LAST].g_out.oq;
endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: directed corner vectors plus randomized traffic against
// an arithmetic reference model and an occupancy-based handshake model.
module tb_rca_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(16)) bus16 ();
  rca_pipe_if #(.WIDTH(4))  bus4 ();

  rca_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  rca_pipe #(.WIDTH(4),  .STAGES(4)) u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  function automatic longint ref_s(int unsigned w, longint a, longint b, bit cin, bit sub);
    longint m = longint'(1) << (w + 1);
    if (sub) return (a + (longint'(1) << w) - b - longint'(cin)) % m;
    return (a + b + longint'(cin)) % m;
  endfunction

  function automatic bit ref_ovf(int unsigned w, longint a, longint b, bit cin, bit sub);
    longint h  = longint'(1) << (w - 1);
    longint sa = (a >= h) ? a - 2 * h : a;
    longint sb = (b >= h) ? b - 2 * h : b;
    longint r  = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    return (r < -h) || (r >= h);
  endfunction

  task automatic idle_all;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
    bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
    bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus16.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus16.in_ready); end
    n_vec++; if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
    n_vec++; if (bus16.s !== 17'h0) begin n_bad++; $display("FAIL reset_s: got %h want 00000", bus16.s); end
    n_vec++; if (bus16.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus16.ovf); end
    n_vec++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid4: got %b want 0", bus4.out_valid); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus16.in_ready); end
  endtask

  task automatic test_sub16;
    logic [15:0] ta [3] = '{16'h0005, 16'h8000, 16'h0000};
    logic [15:0] tb [3] = '{16'h0007, 16'h0001, 16'h0000};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [16:0] es [3] = '{17'h0FFFE, 17'h17FFF, 17'h0FFFF};
    logic        eo [3] = '{1'b0, 1'b1, 1'b0};
    int cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.a = ta[i]; bus16.b = tb[i];
      bus16.cin = tc[i]; bus16.sub = 1'b1; bus16.out_ready = 1'b1;
      #1;
      n_vec++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL sub_accept[%0d]: got %b want 1", i, bus16.in_ready); end
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      cnt = 1;
      while (cnt <= 20) begin
        @(negedge clk); #1;
        if (bus16.out_valid === 1'b1) break;
        cnt++;
      end
      n_vec++; if (cnt != 4) begin n_bad++; $display("FAIL sub_latency[%0d]: got %0d want 4", i, cnt); end
      n_vec++; if (bus16.s !== es[i]) begin n_bad++; $display("FAIL sub_s[%0d]: got %h want %h", i, bus16.s, es[i]); end
      n_vec++; if (bus16.ovf !== eo[i]) begin n_bad++; $display("FAIL sub_ovf[%0d]: got %b want %b", i, bus16.ovf, eo[i]); end
    end
  endtask

  task automatic test_wrap4;
    logic [3:0] ta [2] = '{4'hF, 4'h7};
    logic [4:0] es [2] = '{5'h10, 5'h08};
    logic       eo [2] = '{1'b0, 1'b1};
    int cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.a = ta[i]; bus4.b = 4'h1;
      bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
      #1;
      n_vec++; if (bus4.in_ready !== 1'b1) begin n_bad++; $display("FAIL wrap4_accept[%0d]: got %b want 1", i, bus4.in_ready); end
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      cnt = 1;
      while (cnt <= 20) begin
        @(negedge clk); #1;
        if (bus4.out_valid === 1'b1) break;
        cnt++;
      end
      n_vec++; if (cnt != 4) begin n_bad++; $display("FAIL wrap4_latency[%0d]: got %0d want 4", i, cnt); end
      n_vec++; if (bus4.s !== es[i]) begin n_bad++; $display("FAIL wrap4_s[%0d]: got %h want %h", i, bus4.s, es[i]); end
      n_vec++; if (bus4.ovf !== eo[i]) begin n_bad++; $display("FAIL wrap4_ovf[%0d]: got %b want %b", i, bus4.ovf, eo[i]); end
    end
  endtask

  task automatic test_ripple16;
    int sent = 0, got = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      bus16.in_valid = (sent < 8); bus16.a = 16'hFFFF; bus16.b = 16'h0000;
      bus16.cin = 1'b1; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
      #1;
      if (bus16.out_valid === 1'b1) begin
        n_vec++; if (bus16.s !== 17'h10000) begin n_bad++; $display("FAIL ripple_s[%0d]: got %h want 10000", got, bus16.s); end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus16.in_valid && bus16.in_ready) sent++;
    end
    bus16.in_valid = 1'b0;
    n_vec++; if (got != 8 || last - first + 1 != 8) begin
      n_bad++; $display("FAIL ripple_stream: got %0d results over %0d cycles want 8 over 8", got, last - first + 1);
    end
  endtask

  task automatic test_backpressure16;
    logic [16:0] q [$];
    logic [16:0] held = '0;
    logic [16:0] exp_s;
    logic        exp_rdy;
    bit          stalled = 1'b0;
    bit          saw_full = 1'b0;
    int occ = 0, sent = 0, got = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      bus16.out_ready = !(cyc >= 3 && cyc < 9);
      bus16.in_valid  = (sent < 10);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
      #1;
      exp_rdy = (occ < 4) || bus16.out_ready;
      if (!exp_rdy) saw_full = 1'b1;
      n_vec++; if (bus16.in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, bus16.in_ready, exp_rdy); end
      if (stalled) begin
        n_vec++; if (bus16.out_valid !== 1'b1 || bus16.s !== held) begin
          n_bad++; $display("FAIL bp_hold[%0d]: got v=%b s=%h want v=1 s=%h", cyc, bus16.out_valid, bus16.s, held);
        end
      end
      if (bus16.out_valid === 1'b1 && bus16.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra[%0d]: got %h want no result", cyc, bus16.s);
        end else begin
          exp_s = q.pop_front();
          if (bus16.s !== exp_s) begin n_bad++; $display("FAIL bp_s[%0d]: got %h want %h", got, bus16.s, exp_s); end
        end
        got++; occ--;
      end
      if (bus16.in_valid && bus16.in_ready === 1'b1) begin
        q.push_back(17'(ref_s(16, longint'(bus16.a), longint'(bus16.b), bus16.cin, bus16.sub)));
        sent++; occ++;
      end
      stalled = (bus16.out_valid === 1'b1) && !bus16.out_ready;
      held    = bus16.s;
    end
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    n_vec++; if (got != 10 || q.size() != 0 || !saw_full) begin
      n_bad++; $display("FAIL bp_complete: got %0d results left %0d full %b want 10 left 0 full 1", got, q.size(), saw_full);
    end
  endtask

  task automatic test_reset_midflight16;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b0;
      #1;
      n_vec++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept[%0d]: got %b want 1", i, bus16.in_ready); end
    end
    @(negedge clk);
    bus16.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", bus16.out_valid); end
    n_vec++; if (bus16.s !== 17'h0) begin n_bad++; $display("FAIL mid_s: got %h want 00000", bus16.s); end
    n_vec++; if (bus16.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready_rst: got %b want 0", bus16.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus16.in_valid = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h1111;
    bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    #1;
    n_vec++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_post_accept: got %b want 1", bus16.in_ready); end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    cnt = 1;
    while (cnt <= 20) begin
      @(negedge clk); #1;
      if (bus16.out_valid === 1'b1) break;
      cnt++;
    end
    n_vec++; if (cnt != 4) begin n_bad++; $display("FAIL mid_latency: got %0d want 4", cnt); end
    n_vec++; if (bus16.s !== 17'h02345) begin n_bad++; $display("FAIL mid_s_post: got %h want 02345", bus16.s); end
  endtask

  task automatic test_random;
    localparam int N = 3000;
    logic [17:0] q16 [$];
    logic [5:0]  q4 [$];
    logic [17:0] e16;
    logic [5:0]  e4;
    logic        exp_rdy;
    int occ16 = 0, occ4 = 0;
    for (int cyc = 0; cyc < N; cyc++) begin
      @(negedge clk);
      bus16.in_valid  = (cyc < N - 20) && ($urandom_range(0, 3) != 0);
      bus16.out_ready = (cyc >= N - 20) || ($urandom_range(0, 3) != 0);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
      bus4.in_valid  = (cyc < N - 20) && ($urandom_range(0, 2) != 0);
      bus4.out_ready = (cyc >= N - 20) || ($urandom_range(0, 2) != 0);
      bus4.a = 4'($urandom); bus4.b = 4'($urandom);
      bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
      #1;
      exp_rdy = (occ16 < 4) || bus16.out_ready;
      n_vec++; if (bus16.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd16_in_ready[%0d]: got %b want %b", cyc, bus16.in_ready, exp_rdy); end
      exp_rdy = (occ4 < 4) || bus4.out_ready;
      n_vec++; if (bus4.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd4_in_ready[%0d]: got %b want %b", cyc, bus4.in_ready, exp_rdy); end
      if (bus16.out_valid === 1'b1 && bus16.out_ready) begin
        n_vec++;
        if (q16.size() == 0) begin
          n_bad++; $display("FAIL rnd16_extra[%0d]: got %h want no result", cyc, bus16.s);
        end else begin
          e16 = q16.pop_front();
          if ({bus16.ovf, bus16.s} !== e16) begin
            n_bad++; $display("FAIL rnd16_result[%0d]: got ovf=%b s=%h want ovf=%b s=%h", cyc, bus16.ovf, bus16.s, e16[17], e16[16:0]);
          end
        end
        occ16--;
      end
      if (bus4.out_valid === 1'b1 && bus4.out_ready) begin
        n_vec++;
        if (q4.size() == 0) begin
          n_bad++; $display("FAIL rnd4_extra[%0d]: got %h want no result", cyc, bus4.s);
        end else begin
          e4 = q4.pop_front();
          if ({bus4.ovf, bus4.s} !== e4) begin
            n_bad++; $display("FAIL rnd4_result[%0d]: got ovf=%b s=%h want ovf=%b s=%h", cyc, bus4.ovf, bus4.s, e4[5], e4[4:0]);
          end
        end
        occ4--;
      end
      if (bus16.in_valid && bus16.in_ready === 1'b1) begin
        q16.push_back({ref_ovf(16, longint'(bus16.a), longint'(bus16.b), bus16.cin, bus16.sub),
                       17'(ref_s(16, longint'(bus16.a), longint'(bus16.b), bus16.cin, bus16.sub))});
        occ16++;
      end
      if (bus4.in_valid && bus4.in_ready === 1'b1) begin
        q4.push_back({ref_ovf(4, longint'(bus4.a), longint'(bus4.b), bus4.cin, bus4.sub),
                      5'(ref_s(4, longint'(bus4.a), longint'(bus4.b), bus4.cin, bus4.sub))});
        occ4++;
      end
    end
    idle_all();
    n_vec++; if (q16.size() != 0 || q4.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain: got %0d/%0d pending want 0/0", q16.size(), q4.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_sub16();
    test_wrap4();
    test_ripple16();
    test_backpressure16();
    test_reset_midflight16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
